// File: rtl/prim_filter_evt.sv
// Event stage after the input filter: sticky rise/fall/hold-pending bits per channel plus one irq.
// Optional overflow tracking (evt_ovf_o) is built when PRIM_FILTER_EVT_OVF_EN is defined.
module prim_filter_evt #(
    parameter int Width      = 4,
    parameter int HoldCycles = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] level_i,
    input  logic [Width-1:0] enable_i,
    input  logic             rise_en_i,
    input  logic             fall_en_i,
    input  logic             hold_en_i,
    input  logic [Width-1:0] clr_i,
    output logic [Width-1:0] evt_rise_o,
    output logic [Width-1:0] evt_fall_o,
    output logic [Width-1:0] evt_hold_o,
`ifdef PRIM_FILTER_EVT_OVF_EN
    output logic [Width-1:0] evt_ovf_o,
`endif
    output logic             irq_o
);

    localparam int CtrW = $clog2(HoldCycles);
    localparam logic [CtrW-1:0] CtrMax = CtrW'(HoldCycles - 2);

    typedef enum logic [1:0] {
        ST_LOW  = 2'd0,
        ST_CNT  = 2'd1,
        ST_HELD = 2'd2
    } state_e;

    logic [Width-1:0] level_q;
    logic [Width-1:0] rise, fall, hold_raw;
    logic [Width-1:0] rise_evt, fall_evt, hold_evt;
    logic [Width-1:0] rise_q, rise_d, fall_q, fall_d, hold_q, hold_d;
    logic             irq_q, irq_d;

    // level_q tracks the input even in reset so a level held high across reset is not a rise.
    always_ff @(posedge clk_i) begin
        level_q <= level_i;
    end

    assign rise = level_i & ~level_q;
    assign fall = ~level_i & level_q;

    generate
        for (genvar gi = 0; gi < Width; gi++) begin : g_chan
            state_e          state_q, state_d;
            logic [CtrW-1:0] ctr_q, ctr_d;
            logic            hold_hit;

            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    state_q <= ST_LOW;
                    ctr_q   <= '0;
                end else begin
                    state_q <= state_d;
                    ctr_q   <= ctr_d;
                end
            end

            always_comb begin
                state_d  = state_q;
                ctr_d    = ctr_q;
                hold_hit = 1'b0;
                if (!enable_i[gi]) begin
                    state_d = ST_LOW;
                    ctr_d   = '0;
                end else begin
                    case (state_q)
                        ST_LOW: begin
                            if (rise[gi]) begin
                                state_d = ST_CNT;
                                ctr_d   = '0;
                            end
                        end
                        ST_CNT: begin
                            if (!level_i[gi]) begin
                                state_d = ST_LOW;
                                ctr_d   = '0;
                            end else if (ctr_q == CtrMax) begin
                                state_d  = ST_HELD;
                                hold_hit = 1'b1;
                            end else begin
                                ctr_d = ctr_q + CtrW'(1);
                            end
                        end
                        ST_HELD: begin
                            if (!level_i[gi]) begin
                                state_d = ST_LOW;
                                ctr_d   = '0;
                            end
                        end
                        default: begin
                            state_d = ST_LOW;
                            ctr_d   = '0;
                        end
                    endcase
                end
            end

            assign hold_raw[gi] = hold_hit;
        end
    endgenerate

    assign rise_evt = rise & enable_i & {Width{rise_en_i}};
    assign fall_evt = fall & enable_i & {Width{fall_en_i}};
    assign hold_evt = hold_raw & {Width{hold_en_i}};

    // Set has priority over a simultaneous clear.
    assign rise_d = (rise_q & ~clr_i) | rise_evt;
    assign fall_d = (fall_q & ~clr_i) | fall_evt;
    assign hold_d = (hold_q & ~clr_i) | hold_evt;

`ifdef PRIM_FILTER_EVT_OVF_EN
    logic [Width-1:0] ovf_q, ovf_d;

    assign ovf_d = (ovf_q & ~clr_i) |
                   (rise_evt & rise_q) | (fall_evt & fall_q) | (hold_evt & hold_q);
    assign irq_d = |{rise_d, fall_d, hold_d, ovf_d};

    always_ff @(posedge clk_i) begin
        if (!rst_ni) ovf_q <= '0;
        else         ovf_q <= ovf_d;
    end

    assign evt_ovf_o = ovf_q;
`else
    assign irq_d = |{rise_d, fall_d, hold_d};
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rise_q <= '0;
            fall_q <= '0;
            hold_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
            hold_q <= hold_d;
            irq_q  <= irq_d;
        end
    end

    assign evt_rise_o = rise_q;
    assign evt_fall_o = fall_q;
    assign evt_hold_o = hold_q;
    assign irq_o      = irq_q;

endmodule

// File: tb/tb_prim_filter_evt.sv
// Self-checking bench for prim_filter_evt: directed vector table, hold/disable/overflow
// sequences, and randomized traffic compared against a run-length reference model.
module tb_prim_filter_evt;

    localparam int W    = 4;
    localparam int HOLD = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] level, enable, clr;
    logic         rise_en, fall_en, hold_en;
    logic [W-1:0] evt_rise, evt_fall, evt_hold;
    logic         irq;
`ifdef PRIM_FILTER_EVT_OVF_EN
    logic [W-1:0] evt_ovf;
`endif

    always #5 clk = ~clk;

    prim_filter_evt #(.Width(W), .HoldCycles(HOLD)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .level_i    (level),
        .enable_i   (enable),
        .rise_en_i  (rise_en),
        .fall_en_i  (fall_en),
        .hold_en_i  (hold_en),
        .clr_i      (clr),
        .evt_rise_o (evt_rise),
        .evt_fall_o (evt_fall),
        .evt_hold_o (evt_hold),
`ifdef PRIM_FILTER_EVT_OVF_EN
        .evt_ovf_o  (evt_ovf),
`endif
        .irq_o      (irq)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a channel is "armed" from an enabled rise and counts consecutive
    // high samples; the hold event is the HOLD-th such sample.
    logic [W-1:0] m_prev, m_rise, m_fall, m_hold, m_ovf;
    logic         m_irq;
    bit           m_armed [W];
    int           m_run   [W];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        logic [W-1:0] r, f, h, ovf_set;
        r = '0; f = '0; h = '0;
        if (!rst_n) begin
            m_prev = level;
            m_rise = '0; m_fall = '0; m_hold = '0; m_ovf = '0; m_irq = 1'b0;
            for (int c = 0; c < W; c++) begin
                m_armed[c] = 0;
                m_run[c]   = 0;
            end
            return;
        end
        for (int c = 0; c < W; c++) begin
            if (!enable[c]) begin
                m_armed[c] = 0;
                m_run[c]   = 0;
            end else begin
                r[c] = level[c] & ~m_prev[c] & rise_en;
                f[c] = ~level[c] & m_prev[c] & fall_en;
                if (level[c] && !m_prev[c]) begin
                    m_armed[c] = 1;
                    m_run[c]   = 1;
                end else if (!level[c]) begin
                    m_armed[c] = 0;
                    m_run[c]   = 0;
                end else if (m_armed[c]) begin
                    m_run[c]++;
                    if (m_run[c] == HOLD) h[c] = hold_en;
                end
            end
        end
        ovf_set = (r & m_rise) | (f & m_fall) | (h & m_hold);
        m_rise  = (m_rise & ~clr) | r;
        m_fall  = (m_fall & ~clr) | f;
        m_hold  = (m_hold & ~clr) | h;
        m_ovf   = (m_ovf & ~clr) | ovf_set;
`ifdef PRIM_FILTER_EVT_OVF_EN
        m_irq   = |{m_rise, m_fall, m_hold, m_ovf};
`else
        m_irq   = |{m_rise, m_fall, m_hold};
`endif
        m_prev  = level;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check("model", {19'd0, evt_rise, evt_fall, evt_hold, irq}, {19'd0, m_rise, m_fall, m_hold, m_irq});
`ifdef PRIM_FILTER_EVT_OVF_EN
        check("model_ovf", {28'd0, evt_ovf}, {28'd0, m_ovf});
`endif
    endtask

    typedef struct {
        logic [W-1:0] level;
        logic [W-1:0] clr;
        logic [W-1:0] exp_rise;
        logic [W-1:0] exp_fall;
        logic         exp_irq;
    } vec_t;

    vec_t vecs [11];

    initial begin
        // ch0 rise/fall/clear, then ch2 rise colliding with its own clear
        vecs[0]  = '{4'h1, 4'h0, 4'h1, 4'h0, 1'b1};
        vecs[1]  = '{4'h1, 4'h0, 4'h1, 4'h0, 1'b1};
        vecs[2]  = '{4'h1, 4'h0, 4'h1, 4'h0, 1'b1};
        vecs[3]  = '{4'h1, 4'h0, 4'h1, 4'h0, 1'b1};
        vecs[4]  = '{4'h1, 4'h0, 4'h1, 4'h0, 1'b1};
        vecs[5]  = '{4'h0, 4'h0, 4'h1, 4'h1, 1'b1};
        vecs[6]  = '{4'h0, 4'h1, 4'h0, 4'h0, 1'b0};
        vecs[7]  = '{4'h4, 4'h4, 4'h4, 4'h0, 1'b1};
        vecs[8]  = '{4'h4, 4'h4, 4'h0, 4'h0, 1'b0};
        vecs[9]  = '{4'h0, 4'h0, 4'h0, 4'h4, 1'b1};
        vecs[10] = '{4'h0, 4'hF, 4'h0, 4'h0, 1'b0};

        rst_n = 1'b0; level = 4'hF; enable = 4'hF; clr = '0;
        rise_en = 1'b1; fall_en = 1'b1; hold_en = 1'b1;

        // Reset with levels high, then release: no rise may appear.
        for (int i = 0; i < 2; i++) begin
            step();
            check("reset_outputs", {19'd0, evt_rise, evt_fall, evt_hold, irq}, 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("no_rise_after_reset", {28'd0, evt_rise}, 32'd0);
        end
        $display("reset sequence done");
        level = '0; step();
        clr = 4'hF; step(); clr = '0;

        for (int i = 0; i < 11; i++) begin
            level = vecs[i].level;
            clr   = vecs[i].clr;
            step();
            check("vec_rise", {28'd0, evt_rise}, {28'd0, vecs[i].exp_rise});
            check("vec_fall", {28'd0, evt_fall}, {28'd0, vecs[i].exp_fall});
            check("vec_irq",  {31'd0, irq},      {31'd0, vecs[i].exp_irq});
            $display("vec %0d: level=%h clr=%h rise=%h fall=%h irq=%b",
                     i, level, clr, evt_rise, evt_fall, irq);
        end
        clr = '0;

        // Hold on ch1: fires exactly on the 16th high sample, once.
        for (int i = 1; i <= HOLD; i++) begin
            level = 4'h2;
            step();
            check("hold_16", {31'd0, evt_hold[1]}, {31'd0, (i == HOLD)});
        end
        clr = 4'h2; step(); clr = '0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_once", {31'd0, evt_hold[1]}, 32'd0);
        end
        $display("hold sequence 16 high samples done");
        level = '0; step();
        clr = 4'hF; step(); clr = '0;
        level = 4'h2;
        for (int i = 0; i < HOLD - 1; i++) step();
        level = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_15_none", {31'd0, evt_hold[1]}, 32'd0);
        end
        $display("hold sequence 15 high samples done");
        clr = 4'hF; step(); clr = '0;

        // Disabled ch3 toggling sets nothing; enabling while high gives no rise.
        enable = 4'b0111;
        for (int i = 0; i < 8; i++) begin
            level[3] = i[0];
            step();
            check("disabled_ch3", {29'd0, evt_rise[3], evt_fall[3], evt_hold[3]}, 32'd0);
        end
        enable = 4'hF;
        for (int i = 0; i < 3; i++) begin
            step();
            check("enable_while_high", {31'd0, evt_rise[3]}, 32'd0);
        end
        level[3] = 1'b0; step();
        level[3] = 1'b1; step();
        check("rise_after_reenable", {31'd0, evt_rise[3]}, 32'd1);
        $display("disable sequence done");
        level = '0; step();
        clr = 4'hF; step(); clr = '0;

        // Two rises on ch0 without a clear.
        level = 4'h1; step();
        level = 4'h0; step();
        level = 4'h1; step();
        check("double_rise", {31'd0, evt_rise[0]}, 32'd1);
`ifdef PRIM_FILTER_EVT_OVF_EN
        check("ovf_set", {31'd0, evt_ovf[0]}, 32'd1);
`endif
        clr = 4'h1; step(); clr = '0;
        check("double_rise_clr", {31'd0, evt_rise[0]}, 32'd0);
`ifdef PRIM_FILTER_EVT_OVF_EN
        check("ovf_clr", {31'd0, evt_ovf[0]}, 32'd0);
`endif
        $display("overflow sequence done");

        // Randomized traffic against the model (step() does the comparison).
        for (int i = 0; i < 4000; i++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            for (int c = 0; c < W; c++)
                if ($urandom_range(0, 7) == 0) level[c] = ~level[c];
            if ($urandom_range(0, 39) == 0) enable = W'($urandom | $urandom);
            if ($urandom_range(0, 59) == 0) begin
                rise_en = ($urandom_range(0, 3) != 0);
                fall_en = ($urandom_range(0, 3) != 0);
                hold_en = ($urandom_range(0, 3) != 0);
            end
            clr = ($urandom_range(0, 5) == 0) ? W'($urandom) : '0;
            step();
        end
        $display("random phase done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
